// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the RAM arbiter
//
// Purpose: common word and RAM-handshake types plus the arbiter state
// encoding and its default streak limit.
// Contents:
//   word_t              32-bit data/address word
//   ramstate_t          RAM handshake status (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t         arbiter grant state (IDLE, IGNT, DGNT, RETRY)
//   ARB_MAX_DSTREAK_DEF default number of back-to-back D grants while I waits
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IGNT  = 2'd1,
    DGNT  = 2'd2,
    RETRY = 2'd3
  } arb_state_t;

  localparam int ARB_MAX_DSTREAK_DEF = 4;

endpackage

// File: rtl/arb_streak_counter.sv
// rtl/arb_streak_counter.sv - saturating up/clear counter for D-grant streaks
//
// Purpose: counts consecutive data completions that happened while a fetch
// was waiting; saturates at MAX, clear wins over increment.
// Ports:
//   clk    in  1  clock
//   rst    in  1  synchronous active-high reset
//   inc    in  1  count one more D completion
//   clr    in  1  return to zero
//   count  out W  current streak, never above MAX
module arb_streak_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between fetch (I) and data (D)
//
// Purpose: grants the RAM to the data port first, but after MAX_DSTREAK data
// completions with a fetch waiting the next grant goes to the fetch. A grant
// is held until the RAM answers ACCESS; ERROR costs one RETRY cycle with the
// enables dropped, then the same grant is re-presented.
// Optional feature macro: MEM_ARB_STATS_EN adds completion/error counters.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         fetch request and word address
//   iwait, iload        fetch stall (0 only in completion cycle), fetch data
//   dREN, dWEN          data read / write request (dWEN wins if both)
//   daddr, dstore       data address and write data
//   dwait, dload        data stall (0 only in completion cycle), read data
//   ramREN, ramWEN      RAM enables
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramstate   RAM read data and handshake status
//   igrants, dgrants,   (MEM_ARB_STATS_EN) completed I, completed D,
//   errcnt              ERROR responses; wrap at 2^STAT_W
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = ARB_MAX_DSTREAK_DEF
`ifdef MEM_ARB_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
  , output logic [STAT_W-1:0] igrants
  , output logic [STAT_W-1:0] dgrants
  , output logic [STAT_W-1:0] errcnt
`endif
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t    state;
  logic          retry_d;   // which grant RETRY returns to
  ramstate_t     rs;
  logic          d_req;
  logic [SW-1:0] streak;
  logic          streak_full;
  logic          i_done;
  logic          d_done;
  logic          i_err;
  logic          d_err;

  assign rs          = ramstate_t'(ramstate);
  assign d_req       = dREN | dWEN;
  assign streak_full = (streak == SW'(MAX_DSTREAK));

  // A requester that has dropped its enable is treated as withdrawn, so a
  // late ACCESS/ERROR in that cycle is ignored. Reset abandons the access
  // without releasing the wait.
  assign i_done = !RST && (state == IGNT) && iREN  && (rs == ACCESS);
  assign d_done = !RST && (state == DGNT) && d_req && (rs == ACCESS);
  assign i_err  = !RST && (state == IGNT) && iREN  && (rs == ERROR);
  assign d_err  = !RST && (state == DGNT) && d_req && (rs == ERROR);

  arb_streak_counter #(
    .MAX (MAX_DSTREAK),
    .W   (SW)
  ) u_streak (
    .clk   (CLK),
    .rst   (RST),
    .inc   (d_done && iREN),
    .clr   (i_done || ((state == IDLE) && !iREN)),
    .count (streak)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      retry_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !(iREN && streak_full)) begin
            state <= DGNT;
          end else if (iREN) begin
            state <= IGNT;
          end
        end
        IGNT: begin
          if (!iREN || i_done) begin
            state <= IDLE;
          end else if (i_err) begin
            state   <= RETRY;
            retry_d <= 1'b0;
          end
        end
        DGNT: begin
          if (!d_req || d_done) begin
            state <= IDLE;
          end else if (d_err) begin
            state   <= RETRY;
            retry_d <= 1'b1;
          end
        end
        RETRY: begin
          state <= retry_d ? DGNT : IGNT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      DGNT: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = ~i_done;
  assign dwait = ~d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      igrants <= '0;
      dgrants <= '0;
      errcnt  <= '0;
    end else begin
      if (i_done) igrants <= igrants + 1'b1;
      if (d_done) dgrants <= dgrants + 1'b1;
      if (i_err || d_err) errcnt <= errcnt + 1'b1;
    end
  end
`endif

endmodule
